vreg_op_scheduler: RTL and testbench
====================================

// Module: vreg_op_scheduler
// PURPOSE
//  Shares one 4-bit versatile register (PIPO load / count / shift / LFSR) among NREQ requesters.
//  Each requester asks for one op code and a run length in clock cycles.
//  A round-robin arbiter grants one requester at a time and drives the register's C code and enable.
//  At the end of the run it captures Q, returns it to the granted requester and pulses done.
// PARAMETERS
//  NREQ   4  number of requesters, 2..8
//  LEN_W  4  run-length width; a run lasts 1..2^LEN_W-1 cycles
// PORTS
//  clk        in   1           rising-edge clock
//  reset_n    in   1           asynchronous, active-low reset
//  req        in   NREQ        per-requester request level; held high until done or to abort
//  req_op     in   2*NREQ      op code of requester i at [2i+1:2i]: 00 load, 01 count, 10 shift, 11 lfsr
//  req_len    in   LEN_W*NREQ  run length of requester i at [LEN_W*(i+1)-1:LEN_W*i]
//  vreg_q     in   4           current {Q3,Q2,Q1,Q0} of the register
//  vreg_c     out  2           C code to the register
//  vreg_en    out  1           register clock-enable; register holds when 0
//  gnt        out  NREQ        one-hot grant; high for the whole RUN state
//  busy       out  1           high in RUN and DONE
//  done       out  1           one-cycle completion pulse
//  done_id    out  $clog2(NREQ)  index of the requester being completed; valid with done
//  aborted    out  1           valid with done; 1 if the run ended early because req dropped
//  result     out  4           vreg_q captured at the end of the run; stable until next done
// BEHAVIOUR
//  Reset (async on reset_n low):
//   - state=IDLE; vreg_c=00; vreg_en=0; gnt=0; busy=0; done=0; done_id=0; aborted=0; result=0.
//   - RR pointer=0, so requester 0 has highest priority first.
//   - reset_n low in mid-run abandons the run immediately; no done pulse is issued.
//  FSM IDLE -> RUN -> DONE -> IDLE, one state per cycle except RUN.
//   IDLE:
//    - If any req bit is high, select the first set bit at or after ptr, wrapping at NREQ.
//    - Latch id, op and len for that requester; cnt=len (len=0 is coerced to 1); go to RUN.
//    - If no req bit is high, remain in IDLE.
//    - Outputs in IDLE: vreg_en=0, gnt=0.
//   RUN:
//    - gnt[id]=1, vreg_en=1, vreg_c=latched op (held constant for the whole run).
//    - cnt decrements each cycle; when cnt==1, go to DONE.
//    - The register therefore steps exactly len times.
//    - If req[id] is low in a RUN cycle, that cycle still enables the register; go to DONE with aborted=1.
//    - Other requesters' op/len changes are ignored; id's inputs are ignored after latching.
//   DONE:
//    - vreg_en=0, gnt=0, done=1, done_id=id, result<=vreg_q (post-run value).
//    - ptr<=(id+1) mod NREQ; next state is IDLE.
//  Latency:
//   - req high in IDLE cycle t gives gnt at t+1, last enable at t+len, done at t+len+1.
//   - Minimum request-to-request spacing is len+2 cycles.
//  Fairness: after completing requester i, every other active requester is served before i again.
//  vreg_c and vreg_en are registered outputs; there is no combinational path from req.
// TESTING
//  1. Reset: reset_n=0 mid-RUN -> all outputs 0 immediately; after release, IDLE, no done pulse.
//  2. Single request: req=0001, op=01, len=5, vreg_q counting from 0 -> 5 enabled cycles; done at t+6; result=4'h5; done_id=0.
//  3. Round robin: req=1111 held continuously, each len=1 -> grants 0,1,2,3,0 in that order, one done every 3 cycles.
//  4. Abort: req[2] op=10 len=8, drop req[2] after 3 RUN cycles -> 4 enabled cycles; done with aborted=1; result = 4-step shifted value.
//  5. len=0: req=0010, len=0 -> exactly 1 enabled cycle, then done.
//  6. Op isolation: change req_op[1:0] during RUN -> vreg_c stays at the latched code for every RUN cycle.

Source files
------------

// File: rtl/vreg_op_scheduler.sv
// Round-robin scheduler sharing one 4-bit versatile register among NREQ requesters.
// Each granted requester runs its op for len cycles; Q is captured and returned with a done pulse.
module vreg_op_scheduler #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [LEN_W*NREQ-1:0]    req_len,
  input  logic [3:0]               vreg_q,
  output logic [1:0]               vreg_c,
  output logic                     vreg_en,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     aborted,
  output logic [3:0]               result
);

  // state  | meaning
  // IDLE   | waiting for any req; arbitrate from ptr
  // RUN    | register enabled with latched op, cnt counts down to 1
  // DONE   | capture vreg_q into result, pulse done, advance ptr
  localparam int ID_W = $clog2(NREQ);
  localparam int SW   = ID_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] cnt;

  logic             found;
  logic [ID_W-1:0]  sel;
  logic [1:0]       sel_op;
  logic [LEN_W-1:0] sel_len;
  logic [ID_W-1:0]  ptr_next;

  // First requester at or after ptr, wrapping at NREQ.
  always_comb begin
    logic [SW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + SW'(k);
      if (idx >= SW'(NREQ)) idx = idx - SW'(NREQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[ID_W-1:0];
      end
    end
  end

  assign sel_op   = req_op[2*sel +: 2];
  assign sel_len  = req_len[LEN_W*sel +: LEN_W];
  assign ptr_next = (id_q == ID_W'(NREQ-1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      id_q    <= '0;
      op_q    <= 2'b00;
      cnt     <= '0;
      aborted <= 1'b0;
      result  <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            id_q    <= sel;
            op_q    <= sel_op;
            cnt     <= (sel_len == '0) ? LEN_W'(1) : sel_len;
            aborted <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt - LEN_W'(1);
          if (!req[id_q]) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end else if (cnt == LEN_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // vreg_q already reflects the last enabled step here.
          result <= vreg_q;
          ptr    <= ptr_next;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (state == S_RUN) gnt[id_q] = 1'b1;
  end

  assign vreg_c  = op_q;
  assign vreg_en = (state == S_RUN);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign done_id = id_q;

endmodule

// File: tb/tb_vreg_op_scheduler.sv
// Directed bench for vreg_op_scheduler; a behavioural 4-bit register answers vreg_c/vreg_en.
module tb_vreg_op_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [15:0] req_len;
  logic [3:0]  vq = 4'h0;
  logic [1:0]  vreg_c;
  logic        vreg_en;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        aborted;
  logic [3:0]  result;

  logic        q_set = 1'b0;
  logic [3:0]  q_init = 4'h0;

  int checks = 0;
  int failures = 0;

  vreg_op_scheduler #(.NREQ(4), .LEN_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op), .req_len(req_len),
    .vreg_q(vq), .vreg_c(vreg_c), .vreg_en(vreg_en), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .aborted(aborted), .result(result)
  );

  always #5 clk = ~clk;

  // Register: load=A, count=+1, shift=Johnson left, lfsr={q[2:0],q3^q2}
  always @(posedge clk) begin
    if (q_set) vq <= q_init;
    else if (vreg_en) begin
      case (vreg_c)
        2'b00:   vq <= 4'hA;
        2'b01:   vq <= vq + 4'd1;
        2'b10:   vq <= {vq[2:0], ~vq[3]};
        default: vq <= {vq[2:0], vq[3] ^ vq[2]};
      endcase
    end
  end

  task automatic set_q(input logic [3:0] v);
    @(negedge clk);
    q_init = v;
    q_set  = 1'b1;
    @(negedge clk);
    q_set  = 1'b0;
  endtask

  task automatic wait_done(input int limit, input logic [1:0] exp_c,
                           output int cyc, output int ens, output int badc, output bit ok);
    cyc = 0; ens = 0; badc = 0; ok = 1'b0;
    while (cyc < limit && !ok) begin
      @(negedge clk);
      cyc++;
      if (vreg_en) begin
        ens++;
        if (vreg_c !== exp_c) badc++;
      end
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    int bad;
    reset_n = 1'b0; req = 4'h0; req_op = 8'h0; req_len = 16'h0;
    repeat (3) @(negedge clk);
    outs = {vreg_c, vreg_en, gnt, busy, done, done_id, aborted, result};
    checks++;
    if (outs !== 18'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    reset_n = 1'b1;
    set_q(4'h0);
    req_op = 8'h01; req_len = 16'h000F; req = 4'b0001;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0001) begin
      failures++; $display("FAIL reset_prerun busy=%b gnt=%b exp busy=1 gnt=0001", busy, gnt);
    end
    reset_n = 1'b0;
    #1;
    outs = {vreg_c, vreg_en, gnt, busy, done, done_id, aborted, result};
    checks++;
    if (outs !== 18'h0) begin failures++; $display("FAIL reset_midrun got=%h exp=0", outs); end
    req = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_no_done bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_round_robin();
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int n, cyc, last, gbad;
    logic [3:0] exp_g;
    req_op = 8'h55; req_len = 16'h1111; req = 4'hF;
    n = 0; cyc = 0; last = 0; gbad = 0;
    while (cyc < 40 && n < 5) begin
      @(negedge clk);
      cyc++;
      if (vreg_en) begin
        exp_g = 4'b0001 << exp_ids[n];
        if (gnt !== exp_g) gbad++;
      end
      if (done === 1'b1) begin
        checks++;
        if (done_id !== 2'(exp_ids[n])) begin
          failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", n, done_id, exp_ids[n]);
        end
        checks++;
        if ((n == 0 && cyc != 2) || (n > 0 && cyc - last != 3)) begin
          failures++; $display("FAIL rr_spacing[%0d] got_cycle=%0d last=%0d", n, cyc, last);
        end
        last = cyc;
        n++;
        if (n == 5) req = 4'h0;
      end
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL rr_timeout dones=%0d exp=5", n); end
    checks++;
    if (gbad != 0) begin failures++; $display("FAIL rr_gnt bad=%0d exp=0", gbad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int cyc, ens, badc;
    bit ok;
    set_q(4'h0);
    req_op = 8'h01; req_len = 16'h0005; req = 4'b0001;
    wait_done(30, 2'b01, cyc, ens, badc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
    checks++;
    if (cyc != 6 || ens != 5) begin
      failures++; $display("FAIL single_timing done_cyc=%0d ens=%0d exp 6/5", cyc, ens);
    end
    checks++;
    if (done_id !== 2'd0 || aborted !== 1'b0 || badc != 0) begin
      failures++; $display("FAIL single_flags id=%0d ab=%b badc=%0d exp 0/0/0", done_id, aborted, badc);
    end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (result !== 4'h5 || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_result res=%h done=%b busy=%b exp 5/0/0", result, done, busy);
    end
  endtask

  task automatic test_abort();
    int cyc, ens;
    bit ok;
    set_q(4'h0);
    req_op = 8'b00_10_00_00; req_len = 16'h0800; req = 4'b0100;
    cyc = 0; ens = 0; ok = 1'b0;
    while (cyc < 20 && !ok) begin
      @(negedge clk);
      cyc++;
      if (vreg_en) ens++;
      if (cyc == 4) req = 4'h0;
      if (done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || cyc != 5 || ens != 4) begin
      failures++; $display("FAIL abort_timing ok=%b done_cyc=%0d ens=%0d exp 1/5/4", ok, cyc, ens);
    end
    checks++;
    if (aborted !== 1'b1 || done_id !== 2'd2) begin
      failures++; $display("FAIL abort_flags ab=%b id=%0d exp 1/2", aborted, done_id);
    end
    @(negedge clk);
    checks++;
    if (result !== 4'hF) begin failures++; $display("FAIL abort_result got=%h exp=f", result); end
  endtask

  task automatic test_len_zero();
    int cyc, ens, badc;
    bit ok;
    set_q(4'h7);
    req_op = 8'b00_00_01_00; req_len = 16'h0000; req = 4'b0010;
    wait_done(20, 2'b01, cyc, ens, badc, ok);
    checks++;
    if (!ok || cyc != 2 || ens != 1) begin
      failures++; $display("FAIL len0_timing ok=%b done_cyc=%0d ens=%0d exp 1/2/1", ok, cyc, ens);
    end
    checks++;
    if (done_id !== 2'd1) begin failures++; $display("FAIL len0_id got=%0d exp=1", done_id); end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (result !== 4'h8) begin failures++; $display("FAIL len0_result got=%h exp=8", result); end
  endtask

  task automatic test_load();
    int cyc, ens, badc;
    bit ok;
    set_q(4'h0);
    req_op = 8'b00_01_01_01; req_len = 16'h2000; req = 4'b1000;
    wait_done(20, 2'b00, cyc, ens, badc, ok);
    checks++;
    if (!ok || ens != 2 || badc != 0 || done_id !== 2'd3) begin
      failures++; $display("FAIL load_run ok=%b ens=%0d badc=%0d id=%0d exp 1/2/0/3", ok, ens, badc, done_id);
    end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (result !== 4'hA) begin failures++; $display("FAIL load_result got=%h exp=a", result); end
  endtask

  task automatic test_op_isolation();
    int cyc, ens, badc;
    bit ok;
    set_q(4'h1);
    req_op = 8'h03; req_len = 16'h0006; req = 4'b0001;
    cyc = 0; ens = 0; badc = 0; ok = 1'b0;
    while (cyc < 20 && !ok) begin
      @(negedge clk);
      cyc++;
      if (vreg_en) begin
        ens++;
        if (vreg_c !== 2'b11) badc++;
      end
      if (cyc == 2) req_op[1:0] = 2'b00;
      if (cyc == 3) begin req_op[1:0] = 2'b10; req_len[3:0] = 4'd1; end
      if (done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (badc != 0) begin failures++; $display("FAIL opiso_vreg_c bad_cycles=%0d exp=0", badc); end
    checks++;
    if (!ok || cyc != 7 || ens != 6) begin
      failures++; $display("FAIL opiso_timing ok=%b done_cyc=%0d ens=%0d exp 1/7/6", ok, cyc, ens);
    end
    req = 4'h0;
    @(negedge clk);
    checks++;
    if (result !== 4'hD) begin failures++; $display("FAIL opiso_result got=%h exp=d", result); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_abort();
    test_len_zero();
    test_load();
    test_op_isolation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
